store_buffer: RTL and testbench

//  Write buffer between the datapath memory-stage signals and the single-port word data memory.

---
 rtl/sb_pkg.sv | 21 ++
 rtl/sb_entry_array.sv | 81 ++++++++
 rtl/store_buffer.sv | 146 ++++++++++++++
 tb/tb_store_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and defaults for the store buffer.
//   sb_state_t : buffer mode (IDLE = empty, ACTIVE = pending stores, FLUSH = draining with stall)
//   sb_entry_t : one queued store {word index, data} at default widths
package sb_pkg;

    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned SB_ADDR_W = 5;
    localparam int unsigned SB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } sb_state_t;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry_array.sv
// Entry storage for the store buffer: address/data registers, valid bits and a parallel
// address comparator.
//   clk_i, rst_i          clock, asynchronous active-high reset (drops all entries)
//   enq_*                 write a new entry at enq_idx_i and mark it valid
//   upd_i, upd_data_i     overwrite the data of the entry matching lookup_addr_i
//   clr_i, clr_idx_i      invalidate an entry (retired to memory)
//   lookup_addr_i         address compared against all valid entries
//   match_o/hit_o         per-entry match vector / any match
//   match_idx_o/_data_o   index and data of the (single) matching entry
//   rd_idx_i, rd_*_o      read port used for the head entry
module sb_entry_array
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enq_i,
    input  logic [IW-1:0]     enq_idx_i,
    input  logic [ADDR_W-1:0] enq_addr_i,
    input  logic [DATA_W-1:0] enq_data_i,
    input  logic              upd_i,
    input  logic [DATA_W-1:0] upd_data_i,
    input  logic              clr_i,
    input  logic [IW-1:0]     clr_idx_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic [DEPTH-1:0]  match_o,
    output logic              hit_o,
    output logic [IW-1:0]     match_idx_o,
    output logic [DATA_W-1:0] match_data_o,
    input  logic [IW-1:0]     rd_idx_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // On a full-miss store the head is retired and refilled in one cycle
            // (clr_idx_i == enq_idx_i); the enqueue below must win.
            if (clr_i) valid_q[clr_idx_i] <= 1'b0;
            if (enq_i) begin
                valid_q[enq_idx_i] <= 1'b1;
                addr_q[enq_idx_i]  <= enq_addr_i;
                data_q[enq_idx_i]  <= enq_data_i;
            end
            if (upd_i) data_q[match_idx_o] <= upd_data_i;
        end
    end

    // Coalescing keeps at most one entry per address, so OR-reducing is a safe mux.
    always_comb begin
        match_o      = '0;
        match_idx_o  = '0;
        match_data_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == lookup_addr_i)) begin
                match_o[i]   = 1'b1;
                match_idx_o  = match_idx_o | IW'(i);
                match_data_o = match_data_o | data_q[i];
            end
        end
    end

    assign hit_o     = |match_o;
    assign rd_addr_o = addr_q[rd_idx_i];
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/store_buffer.sv
// Write buffer between the memory-stage datapath and a single-port word memory. Stores are
// queued (coalesced per address) and retired in free cycles; loads forward from the queue
// or read memory combinationally; flush drains the queue while stalling the datapath.
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_MemWrite/MemRead       store/load request, cpu_Addr word index, cpu_WriteData
//   cpu_ReadData               load result (0 when no load is accepted)
//   flush, stall               drain request / datapath hold
//   mem_*                      memory port (retire write or load read)
//   empty, full, count         occupancy status
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_MemWrite,
    input  logic              cpu_MemRead,
    input  logic [31:0]       cpu_Addr,
    input  logic [DATA_W-1:0] cpu_WriteData,
    output logic [DATA_W-1:0] cpu_ReadData,
    input  logic              flush,
    output logic              stall,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic [31:0]       mem_Addr,
    output logic [DATA_W-1:0] mem_WriteData,
    input  logic [DATA_W-1:0] mem_ReadData,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);

    sb_state_t         state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [ADDR_W-1:0] idx;
    logic              unused_addr_hi;
    logic              flushing, op_wr, op_rd, enq, coal, retire;
    logic              hit;
    logic [DEPTH-1:0]  match;
    logic [PW-1:0]     match_idx;
    logic [DATA_W-1:0] match_data, head_data;
    logic [ADDR_W-1:0] head_addr;

    assign idx            = cpu_Addr[ADDR_W-1:0];
    assign unused_addr_hi = ^cpu_Addr[31:ADDR_W];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A fresh flush request stalls in its own cycle so the drain starts immediately.
    assign flushing = (state_q == FLUSH) || (flush && !empty);
    assign stall    = flushing;
    assign op_wr    = cpu_MemWrite && !flushing;
    assign op_rd    = cpu_MemRead && !cpu_MemWrite && !flushing;
    assign coal     = op_wr && hit;
    assign enq      = op_wr && !hit;
    // The memory port is free unless a load owns it; a full-miss store forces a retire.
    assign retire   = !empty && ((!op_wr && !op_rd) || (enq && full));

    sb_entry_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_entries (
        .clk_i        (clk),
        .rst_i        (reset),
        .enq_i        (enq),
        .enq_idx_i    (tail_q),
        .enq_addr_i   (idx),
        .enq_data_i   (cpu_WriteData),
        .upd_i        (coal),
        .upd_data_i   (cpu_WriteData),
        .clr_i        (retire),
        .clr_idx_i    (head_q),
        .lookup_addr_i(idx),
        .match_o      (match),
        .hit_o        (hit),
        .match_idx_o  (match_idx),
        .match_data_o (match_data),
        .rd_idx_i     (head_q),
        .rd_addr_o    (head_addr),
        .rd_data_o    (head_data)
    );

    always_comb begin
        head_d = retire ? head_q + PW'(1) : head_q;
        tail_d = enq ? tail_q + PW'(1) : tail_q;
        unique case ({enq, retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flushing) state_d = (count_d == '0) ? IDLE : FLUSH;
                else if (enq) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (flushing)            state_d = (count_d == '0) ? IDLE : FLUSH;
                else if (count_d == '0)  state_d = IDLE;
            end
            FLUSH: begin
                if (count_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        mem_MemWrite  = retire;
        mem_MemRead   = op_rd && !hit;
        mem_WriteData = retire ? head_data : '0;
        mem_Addr      = '0;
        if (retire)           mem_Addr = {{(32 - ADDR_W){1'b0}}, head_addr};
        else if (mem_MemRead) mem_Addr = {{(32 - ADDR_W){1'b0}}, idx};
        cpu_ReadData  = '0;
        if (op_rd) cpu_ReadData = hit ? match_data : mem_ReadData;
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_MemWrite = 1'b0, cpu_MemRead = 1'b0, flush = 1'b0;
    logic [31:0] cpu_Addr = '0, cpu_WriteData = '0, cpu_ReadData;
    logic        stall, mem_MemWrite, mem_MemRead, empty, full;
    logic [31:0] mem_Addr, mem_WriteData, mem_ReadData;
    logic [2:0]  count;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_MemWrite (cpu_MemWrite),
        .cpu_MemRead  (cpu_MemRead),
        .cpu_Addr     (cpu_Addr),
        .cpu_WriteData(cpu_WriteData),
        .cpu_ReadData (cpu_ReadData),
        .flush        (flush),
        .stall        (stall),
        .mem_MemWrite (mem_MemWrite),
        .mem_MemRead  (mem_MemRead),
        .mem_Addr     (mem_Addr),
        .mem_WriteData(mem_WriteData),
        .mem_ReadData (mem_ReadData),
        .empty        (empty),
        .full         (full),
        .count        (count)
    );

    // Word memory driven only by the DUT's write port.
    logic [31:0] mem [32];
    logic        mem_init = 1'b0;
    assign mem_ReadData = mem[mem_Addr[4:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (mem_MemWrite) begin
            mem[mem_Addr[4:0]] <= mem_WriteData;
        end
    end

    // Reference model: ordered list of pending stores plus its own memory image.
    typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] data; bit miss; logic [4:0] addr; } rd_t;
    typedef struct { bit stall; int cnt; } st_t;

    ent_t        mq[$];
    logic [31:0] mmem [32];
    bit          mflush = 1'b0;
    ent_t        exp_wr[$];
    rd_t         exp_rd[$];
    st_t         exp_st[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int find(logic [4:0] a);
        foreach (mq[i]) if (mq[i].addr == a) return i;
        return -1;
    endfunction

    function automatic void m_retire();
        ent_t e;
        e = mq.pop_front();
        mmem[e.addr] = e.data;
        exp_wr.push_back(e);
    endfunction

    // Drive one cycle of stimulus and record what the buffer must do in it.
    task automatic cycle(bit we, bit re, logic [4:0] a, logic [31:0] d, bit fl);
        logic [31:0] r;
        bit          fing;
        int          k;
        @(posedge clk);
        #1;
        r             = $urandom();
        cpu_MemWrite  = we;
        cpu_MemRead   = re;
        cpu_Addr      = {r[31:5], a};
        cpu_WriteData = d;
        flush         = fl;
        fing = mflush || (fl && mq.size() > 0);
        exp_st.push_back('{fing, mq.size()});
        if (fing) begin
            m_retire();
            mflush = (mq.size() != 0);
        end else begin
            k = find(a);
            if (we) begin
                if (k >= 0) mq[k].data = d;
                else begin
                    if (mq.size() == DEPTH) m_retire();
                    mq.push_back('{a, d});
                end
            end else if (re) begin
                if (k >= 0) exp_rd.push_back('{mq[k].data, 1'b0, a});
                else        exp_rd.push_back('{mmem[a], 1'b1, a});
            end else if (mq.size() > 0) begin
                m_retire();
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        st_t  s;
        ent_t e;
        rd_t  q;
        if (!reset) begin
            if (exp_st.size() > 0) begin
                s = exp_st.pop_front();
                check("stall", 32'(stall), 32'(s.stall));
                check("count", 32'(count), 32'(s.cnt));
                check("full", 32'(full), 32'(s.cnt == DEPTH));
                check("empty", 32'(empty), 32'(s.cnt == 0));
            end
            if (mem_MemWrite) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_mem_write", mem_Addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", mem_Addr, {27'b0, e.addr});
                    check("wr_data", mem_WriteData, e.data);
                end
            end
            if (cpu_MemRead && !stall) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_load", cpu_ReadData, 32'hFFFF_FFFF);
                end else begin
                    q = exp_rd.pop_front();
                    check("ld_data", cpu_ReadData, q.data);
                    check("ld_memread", 32'(mem_MemRead), 32'(q.miss));
                    if (q.miss) check("ld_addr", mem_Addr, {27'b0, q.addr});
                end
            end else begin
                check("rdata_idle", cpu_ReadData, 32'h0);
            end
        end
    end

    initial begin
        int fl_cnt;
        int op;
        logic [4:0] a;
        #2 reset = 1'b1;
        mem_init = 1'b1;
        for (int i = 0; i < 32; i++) mmem[i] = 32'hC0DE_0000 + 32'(i);
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_mem_we", 32'(mem_MemWrite), 32'h0);
        check("rst_mem_re", 32'(mem_MemRead), 32'h0);
        check("rst_mem_addr", mem_Addr, 32'h0);
        check("rst_mem_wdata", mem_WriteData, 32'h0);
        check("rst_rdata", cpu_ReadData, 32'h0);
        reset = 1'b0;

        // 1: single store retires on an idle cycle
        cycle(1, 0, 5'd3, 32'h11, 0);
        cycle(0, 0, 5'd0, 32'h0, 0);
        cycle(0, 0, 5'd0, 32'h0, 0);
        // 2: forwarding of a queued store
        cycle(1, 0, 5'd5, 32'hAA, 0);
        cycle(0, 1, 5'd5, 32'h0, 0);
        cycle(0, 0, 5'd0, 32'h0, 0);
        // 3: coalescing
        cycle(1, 0, 5'd7, 32'h1, 0);
        cycle(1, 0, 5'd7, 32'h2, 0);
        cycle(0, 0, 5'd0, 32'h0, 0);
        cycle(0, 0, 5'd0, 32'h0, 0);
        // 4: full-miss store retires and enqueues together
        for (int i = 0; i < 4; i++) cycle(1, 0, 5'(i), 32'h50 + 32'(i), 0);
        cycle(1, 0, 5'd9, 32'h99, 0);
        repeat (5) cycle(0, 0, 5'd0, 32'h0, 0);
        // 5: flush of three entries, stores ignored while stalled
        for (int i = 0; i < 3; i++) cycle(1, 0, 5'(20 + i), 32'hF0 + 32'(i), 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 5'd30, 32'hDEAD, 1);
        cycle(0, 0, 5'd0, 32'h0, 1);
        cycle(0, 1, 5'd30, 32'h0, 0);
        // 6: reset in the middle of a flush discards the rest
        for (int i = 0; i < 4; i++) cycle(1, 0, 5'(10 + i), 32'h700 + 32'(i), 0);
        cycle(0, 0, 5'd0, 32'h0, 1);
        cycle(0, 0, 5'd0, 32'h0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cpu_MemWrite = 1'b0;
        cpu_MemRead = 1'b0;
        flush = 1'b0;
        #1;
        check("rst_mid_stall", 32'(stall), 32'h0);
        check("rst_mid_count", 32'(count), 32'h0);
        check("rst_mid_memwe", 32'(mem_MemWrite), 32'h0);
        mq.delete();
        mflush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("discard_12", mem[12], mmem[12]);
        check("discard_13", mem[13], mmem[13]);

        // Random traffic
        fl_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            bit fl;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            if (fl_cnt > 0) begin
                fl = 1'b1;
                fl_cnt--;
            end else begin
                fl = 1'b0;
                if ($urandom_range(0, 24) == 0) fl_cnt = $urandom_range(1, 3);
            end
            if (op <= 3)      cycle(1, 0, a, $urandom(), fl);
            else if (op <= 6) cycle(0, 1, a, 32'h0, fl);
            else              cycle(0, 0, a, 32'h0, fl);
        end
        repeat (8) cycle(0, 0, 5'd0, 32'h0, 0);
        @(negedge clk);
        #1;
        check("pending_writes", 32'(exp_wr.size()), 32'h0);
        check("pending_loads", 32'(exp_rd.size()), 32'h0);
        for (int i = 0; i < 32; i++) check("final_mem", mem[i], mmem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
